// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: oversampled PS/2 receiver with make/break/extended decoding and game-key command pulses
module ps2_key_ctrl #(
    parameter int         TIMEOUT_CYC = 50000,
    parameter logic [7:0] JUMP_CODE   = 8'h29,
    parameter logic [7:0] START_CODE  = 8'h5A,
    parameter logic [7:0] PAUSE_CODE  = 8'h4D
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_ps2,
    input  logic       data_ps2,
    output logic [7:0] scan_code,
    output logic       is_break,
    output logic       is_ext,
    output logic       code_valid,
    output logic       jump,
    output logic       start,
    output logic       pause,
    output logic       jump_held,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [1:0] {R_IDLE, R_DATA, R_PAR, R_STOP} rx_t;
    typedef enum logic [1:0] {D_BASE, D_BRK, D_EXT, D_EXTBRK} dec_t;
    logic [1:0]    r_clk_sync, r_dat_sync;
    logic          r_clk_prev;
    logic          w_s, w_d, w_stop_ok, w_timeout;
    rx_t           r_rx_state, w_rx_next;
    logic [7:0]    r_shift;
    logic [2:0]    r_cnt;
    logic          r_par;
    logic [TW-1:0] r_to_cnt;
    logic          r_byte_rdy, r_frame_err;
    dec_t          r_dec_state, w_dec_next;
    logic          w_evt, w_ext, w_brk;
    logic          r_start_held, r_pause_held;

    assign w_s       = r_clk_prev & ~r_clk_sync[1];
    assign w_d       = r_dat_sync[1];
    assign w_stop_ok = w_d & (^{r_shift, r_par});
    assign w_timeout = (r_rx_state != R_IDLE) && !w_s && (r_to_cnt == TW'(TIMEOUT_CYC));
    assign frame_err = r_frame_err;

    // two-stage synchronizers plus previous clock level for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync <= '0;
            r_dat_sync <= '0;
            r_clk_prev <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], clk_ps2};
            r_dat_sync <= {r_dat_sync[0], data_ps2};
            r_clk_prev <= r_clk_sync[1];
        end
    end

    // receiver state, shift register, timeout counter and one-cycle byte/error strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state  <= R_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_par       <= 1'b0;
            r_to_cnt    <= '0;
            r_byte_rdy  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_state  <= w_rx_next;
            r_byte_rdy  <= w_s && r_rx_state == R_STOP && w_stop_ok;
            r_frame_err <= (w_s && r_rx_state == R_STOP && !w_stop_ok) || w_timeout;
            if (w_s || r_rx_state == R_IDLE)
                r_to_cnt <= '0;
            else if (r_to_cnt != TW'(TIMEOUT_CYC))
                r_to_cnt <= r_to_cnt + TW'(1);
            if (w_s && r_rx_state == R_IDLE)
                r_cnt <= '0;
            if (w_s && r_rx_state == R_DATA) begin
                r_shift <= {w_d, r_shift[7:1]};
                r_cnt   <= r_cnt + 3'd1;
            end
            if (w_s && r_rx_state == R_PAR)
                r_par <= w_d;
        end
    end

    // receiver next state: advances on each PS/2 falling edge, timeout aborts to idle
    always_comb begin
        w_rx_next = r_rx_state;
        if (w_timeout)
            w_rx_next = R_IDLE;
        else if (w_s)
            case (r_rx_state)
                R_IDLE:  w_rx_next = w_d ? R_IDLE : R_DATA;
                R_DATA:  w_rx_next = (r_cnt == 3'd7) ? R_PAR : R_DATA;
                R_PAR:   w_rx_next = R_STOP;
                default: w_rx_next = R_IDLE;
            endcase
    end

    // prefix decoder state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_dec_state <= D_BASE;
        else        r_dec_state <= w_dec_next;
    end

    // prefix sequencing: E0/F0 only act as prefixes where a prefix is still allowed
    always_comb begin
        w_dec_next = r_dec_state;
        w_evt      = 1'b0;
        w_ext      = 1'b0;
        w_brk      = 1'b0;
        if (r_frame_err)
            w_dec_next = D_BASE;
        else if (r_byte_rdy)
            case (r_dec_state)
                D_BASE: begin
                    w_dec_next = (r_shift == 8'hE0) ? D_EXT : (r_shift == 8'hF0) ? D_BRK : D_BASE;
                    w_evt      = r_shift != 8'hE0 && r_shift != 8'hF0;
                end
                D_EXT: begin
                    w_dec_next = (r_shift == 8'hF0) ? D_EXTBRK : D_BASE;
                    w_evt      = r_shift != 8'hF0;
                    w_ext      = 1'b1;
                end
                D_BRK: begin
                    w_dec_next = D_BASE;
                    w_evt      = 1'b1;
                    w_brk      = 1'b1;
                end
                default: begin
                    w_dec_next = D_BASE;
                    w_evt      = 1'b1;
                    w_ext      = 1'b1;
                    w_brk      = 1'b1;
                end
            endcase
    end

    // event outputs and game-key held flags with fresh-press qualification
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_code    <= '0;
            is_break     <= 1'b0;
            is_ext       <= 1'b0;
            code_valid   <= 1'b0;
            jump         <= 1'b0;
            start        <= 1'b0;
            pause        <= 1'b0;
            jump_held    <= 1'b0;
            r_start_held <= 1'b0;
            r_pause_held <= 1'b0;
        end else begin
            code_valid <= w_evt;
            jump       <= 1'b0;
            start      <= 1'b0;
            if (w_evt) begin
                scan_code <= r_shift;
                is_break  <= w_brk;
                is_ext    <= w_ext;
            end
            if (w_evt && !w_ext && r_shift == JUMP_CODE) begin
                jump      <= !w_brk && !jump_held;
                jump_held <= !w_brk;
            end
            if (w_evt && !w_ext && r_shift == START_CODE) begin
                start        <= !w_brk && !r_start_held;
                r_start_held <= !w_brk;
            end
            if (w_evt && !w_ext && r_shift == PAUSE_CODE) begin
                if (!w_brk && !r_pause_held) pause <= !pause;
                r_pause_held <= !w_brk;
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb_ps2_key_ctrl: table-driven byte vectors plus timeout, latency and reset sequences
module tb_ps2_key_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0, clk_ps2 = 1'b1, data_ps2 = 1'b1;
    logic [7:0] scan_code;
    logic       is_break, is_ext, code_valid, jump, start, pause, jump_held, frame_err;
    int n_chk = 0, n_fail = 0;
    int cyc = 0, stop_cyc = 0;
    int n_valid = 0, n_jump = 0, n_start = 0, n_fe = 0;
    int valid_cyc = 0, jump_cyc = 0, fe_cyc = 0;

    typedef struct {
        logic [7:0] b;
        bit         par_ok, stop_ok;
        int         v;
        logic [7:0] code;
        bit         brk, ext;
        int         jmp, st;
        bit         pau, jh;
        int         fe;
    } vec_t;
    vec_t tbl[24];

    ps2_key_ctrl #(.TIMEOUT_CYC(200)) dut (
        .clk(clk), .rst_n(rst_n), .clk_ps2(clk_ps2), .data_ps2(data_ps2),
        .scan_code(scan_code), .is_break(is_break), .is_ext(is_ext), .code_valid(code_valid),
        .jump(jump), .start(start), .pause(pause), .jump_held(jump_held), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // pulse counters and the cycle each pulse was last seen
    always @(negedge clk) begin
        if (code_valid) begin n_valid++; valid_cyc = cyc; end
        if (jump)       begin n_jump++;  jump_cyc  = cyc; end
        if (start)      n_start++;
        if (frame_err)  begin n_fe++;    fe_cyc    = cyc; end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            data_ps2 = bits[i];
            repeat (4) @(negedge clk);
            clk_ps2 = 1'b0;
            if (i == 10) stop_cyc = cyc;
            repeat (8) @(negedge clk);
            clk_ps2 = 1'b1;
        end
        @(negedge clk);
        data_ps2 = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit par_ok, input bit stop_ok);
        logic p;
        p = ~^b ^ ~par_ok;
        send_bits({stop_ok, p, b, 1'b0}, 11);
        repeat (20) @(negedge clk);
    endtask

    task automatic key(input string name, input logic [7:0] b, input int v, input int jmp,
                       input bit brk, input bit jh);
        int v0, j0;
        v0 = n_valid;
        j0 = n_jump;
        send_byte(b, 1'b1, 1'b1);
        check({name, " code_valid"}, n_valid - v0, v);
        check({name, " jump"}, n_jump - j0, jmp);
        if (v != 0) check({name, " is_break"}, is_break, brk);
        check({name, " jump_held"}, jump_held, jh);
    endtask

    initial begin
        tbl[0]  = '{8'h29, 1, 1, 1, 8'h29, 0, 0, 1, 0, 0, 1, 0};
        tbl[1]  = '{8'h29, 1, 1, 1, 8'h29, 0, 0, 0, 0, 0, 1, 0};
        tbl[2]  = '{8'h29, 1, 1, 1, 8'h29, 0, 0, 0, 0, 0, 1, 0};
        tbl[3]  = '{8'hF0, 1, 1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0};
        tbl[4]  = '{8'h29, 1, 1, 1, 8'h29, 1, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{8'h29, 1, 1, 1, 8'h29, 0, 0, 1, 0, 0, 1, 0};
        tbl[6]  = '{8'hE0, 1, 1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0};
        tbl[7]  = '{8'hF0, 1, 1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0};
        tbl[8]  = '{8'h5A, 1, 1, 1, 8'h5A, 1, 1, 0, 0, 0, 1, 0};
        tbl[9]  = '{8'h4D, 1, 1, 1, 8'h4D, 0, 0, 0, 0, 1, 1, 0};
        tbl[10] = '{8'hF0, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1, 1, 0};
        tbl[11] = '{8'h4D, 1, 1, 1, 8'h4D, 1, 0, 0, 0, 1, 1, 0};
        tbl[12] = '{8'h4D, 1, 1, 1, 8'h4D, 0, 0, 0, 0, 0, 1, 0};
        tbl[13] = '{8'h29, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 1};
        tbl[14] = '{8'h5A, 1, 1, 1, 8'h5A, 0, 0, 0, 1, 0, 1, 0};
        tbl[15] = '{8'h5A, 1, 1, 1, 8'h5A, 0, 0, 0, 0, 0, 1, 0};
        tbl[16] = '{8'h29, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 1};
        tbl[17] = '{8'hE0, 1, 1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0};
        tbl[18] = '{8'h29, 1, 1, 1, 8'h29, 0, 1, 0, 0, 0, 1, 0};
        tbl[19] = '{8'hF0, 1, 1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0};
        tbl[20] = '{8'h29, 1, 1, 1, 8'h29, 1, 0, 0, 0, 0, 0, 0};
        tbl[21] = '{8'hF0, 1, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0};
        tbl[22] = '{8'hE0, 1, 1, 1, 8'hE0, 1, 0, 0, 0, 0, 0, 0};
        tbl[23] = '{8'h29, 1, 1, 1, 8'h29, 0, 0, 1, 0, 0, 1, 0};

        repeat (5) @(negedge clk);
        check("reset outputs", {scan_code, is_break, is_ext, code_valid, jump, start, pause, jump_held, frame_err}, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            int v0, j0, s0, f0;
            v0 = n_valid; j0 = n_jump; s0 = n_start; f0 = n_fe;
            send_byte(tbl[i].b, tbl[i].par_ok, tbl[i].stop_ok);
            check($sformatf("v%0d code_valid", i), n_valid - v0, tbl[i].v);
            check($sformatf("v%0d jump", i), n_jump - j0, tbl[i].jmp);
            check($sformatf("v%0d start", i), n_start - s0, tbl[i].st);
            check($sformatf("v%0d frame_err", i), n_fe - f0, tbl[i].fe);
            check($sformatf("v%0d pause", i), pause, tbl[i].pau);
            check($sformatf("v%0d jump_held", i), jump_held, tbl[i].jh);
            if (tbl[i].v != 0) begin
                check($sformatf("v%0d code", i), {scan_code, is_break, is_ext}, {tbl[i].code, tbl[i].brk, tbl[i].ext});
                check($sformatf("v%0d valid latency", i), valid_cyc - stop_cyc, 4);
            end
            if (tbl[i].jmp != 0) check($sformatf("v%0d jump latency", i), jump_cyc - stop_cyc, 4);
            if (tbl[i].fe != 0)  check($sformatf("v%0d err latency", i), fe_cyc - stop_cyc, 3);
        end

        key("pre-timeout F0", 8'hF0, 0, 0, 1'b0, 1'b1);
        key("pre-timeout 29", 8'h29, 1, 0, 1'b1, 1'b0);
        begin
            int v0, f0;
            send_byte(8'hF0, 1'b1, 1'b1);
            v0 = n_valid; f0 = n_fe;
            send_bits({3'b111, 8'b1011_0101}, 6);
            repeat (300) @(negedge clk);
            check("timeout frame_err", n_fe - f0, 1);
            check("timeout code_valid", n_valid - v0, 0);
        end
        key("post-timeout 29", 8'h29, 1, 1, 1'b0, 1'b1);

        key("pause brk F0", 8'hF0, 0, 0, 1'b0, 1'b1);
        key("pause brk 4D", 8'h4D, 1, 0, 1'b1, 1'b1);
        key("pause make", 8'h4D, 1, 0, 1'b0, 1'b1);
        check("pause before reset", pause, 1'b1);

        send_bits({3'b111, 8'h5A}, 4);
        rst_n = 1'b0;
        #1;
        check("mid-frame reset outputs", {scan_code, is_break, is_ext, code_valid, jump, start, pause, jump_held, frame_err}, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        key("after reset 29", 8'h29, 1, 1, 1'b0, 1'b1);
        check("after reset code", scan_code, 8'h29);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
